// File: rtl/bitvec_id_drain.sv
// bitvec_id_drain
// ---------------------------------------------------------------------------
// Purpose: buffers one bit-vector per cycle, with no backpressure, in a small
// FIFO. Each buffered vector is then serialized into the ascending list of its
// set-bit indices, one index per valid/ready beat.
//
// An all-zero vector produces a single marker beat: id_none=1,
// id_last=1, id_out=0. A vector that arrives while the FIFO is full, and no
// entry leaves the FIFO that cycle, is dropped. The drop sets the sticky
// overflow flag.
//
// Ports:
//   clk         in   single clock, posedge
//   rst         in   synchronous active-high reset
//   in          in   BIT_VEC_SIZE vector from the bfpu
//   valid_in    in   vector valid (no ready returned)
//   out_ready   in   downstream accepts the current beat
//   id_out      out  set-bit index of the current beat
//   id_valid    out  beat valid
//   id_last     out  final beat of the current vector
//   id_none     out  marker beat for an all-zero vector
//   count_out   out  popcount of the current vector
//   fifo_level  out  registered FIFO occupancy (excludes the work register)
//   overflow    out  sticky: a vector was dropped
// ---------------------------------------------------------------------------
module bitvec_id_drain #(
  parameter int BIT_VEC_SIZE     = 128,
  parameter int BIT_VEC_SIZE_LOG = 7,
  parameter int DEPTH            = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BIT_VEC_SIZE-1:0]       in,
  input  logic                          valid_in,
  input  logic                          out_ready,
  output logic [BIT_VEC_SIZE_LOG-1:0]   id_out,
  output logic                          id_valid,
  output logic                          id_last,
  output logic                          id_none,
  output logic [BIT_VEC_SIZE_LOG:0]     count_out,
  output logic [$clog2(DEPTH):0]        fifo_level,
  output logic                          overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = BIT_VEC_SIZE_LOG + 1;
  localparam logic [BIT_VEC_SIZE-1:0] WORK_ONE = BIT_VEC_SIZE'(1);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t                     state_q, state_d;
  logic [BIT_VEC_SIZE-1:0]    mem_q [DEPTH];
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]              level_q, level_d;
  logic [BIT_VEC_SIZE-1:0]    work_q, work_d;
  logic [CW-1:0]              count_q, count_d;
  logic                       none_q, none_d;
  logic                       overflow_q, overflow_d;

  logic [BIT_VEC_SIZE-1:0]    head_vec;
  logic [CW-1:0]              head_cnt;
  logic [BIT_VEC_SIZE_LOG-1:0] low_idx;
  logic                       emit;
  logic                       work_single;
  logic                       retire;
  logic                       retire_last;
  logic                       fifo_nonempty;
  logic                       pop;
  logic                       push;

  // -------------------------------------------------------------------------
  // Combinational helpers
  // -------------------------------------------------------------------------
  assign head_vec      = mem_q[rd_ptr_q];
  assign emit          = (state_q == EMIT);
  assign fifo_nonempty = (level_q != '0);

  // At most one bit is set in work. For the beat of an all-zero vector, work
  // is zero, so the beat is also reported as last.
  assign work_single = ((work_q & (work_q - WORK_ONE)) == '0);

  assign retire      = emit && out_ready;
  assign retire_last = retire && work_single;

  // Load the head entry when idle. Also load it when the last beat of the
  // current vector retires, so that back-to-back vectors have no bubble
  // between them.
  assign pop  = fifo_nonempty && (!emit || retire_last);

  // A full FIFO can still accept a vector if its head leaves in the same cycle.
  assign push = valid_in && ((level_q != LW'(DEPTH)) || pop);

  // Lowest set bit of the work register. The loop runs from the top down, so
  // the last match is the lowest set bit.
  always_comb begin
    low_idx = '0;
    for (int i = BIT_VEC_SIZE - 1; i >= 0; i--) begin
      if (work_q[i]) low_idx = BIT_VEC_SIZE_LOG'(i);
    end
  end

  // Popcount of the FIFO head, captured in count_q when the head is loaded.
  always_comb begin
    head_cnt = '0;
    for (int i = 0; i < BIT_VEC_SIZE; i++) begin
      head_cnt = head_cnt + CW'(head_vec[i]);
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (fifo_nonempty) state_d = EMIT;
      EMIT: if (retire_last && !fifo_nonempty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    work_d     = work_q;
    count_d    = count_q;
    none_d     = none_q;
    overflow_d = overflow_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (valid_in && !push) overflow_d = 1'b1;

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      work_d   = head_vec;
      count_d  = head_cnt;
      none_d   = (head_vec == '0);
    end else if (retire) begin
      // Clear the lowest set bit. For the last beat this leaves work at zero.
      work_d = work_q & (work_q - WORK_ONE);
      if (work_single) begin
        count_d = '0;
        none_d  = 1'b0;
      end
    end

    level_d = level_q + LW'(push) - LW'(pop);
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      work_q     <= '0;
      count_q    <= '0;
      none_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      work_q     <= work_d;
      count_q    <= count_d;
      none_q     <= none_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage. The storage itself is not reset; clearing the pointers on
  // reset is enough to discard any queued vectors.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= in;
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    id_valid   = emit;
    id_out     = (emit && !none_q) ? low_idx : '0;
    id_last    = emit && work_single;
    id_none    = emit && none_q;
    count_out  = count_q;
    fifo_level = level_q;
    overflow   = overflow_q;
  end

endmodule

// File: tb/tb_bitvec_id_drain.sv
module tb_bitvec_id_drain;

  localparam int N = 128;
  localparam int DEPTH = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] in_vec;
  logic         valid_in;
  logic         out_ready;
  logic [6:0]   id_out;
  logic         id_valid;
  logic         id_last;
  logic         id_none;
  logic [7:0]   count_out;
  logic [2:0]   fifo_level;
  logic         overflow;

  bitvec_id_drain #(
    .BIT_VEC_SIZE(N), .BIT_VEC_SIZE_LOG(7), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .in(in_vec), .valid_in(valid_in), .out_ready(out_ready),
    .id_out(id_out), .id_valid(id_valid), .id_last(id_last), .id_none(id_none),
    .count_out(count_out), .fifo_level(fifo_level), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model, built from the vector-level rules: a queue of waiting
  // vectors, plus the list of IDs still to be emitted for the current vector.
  logic [N-1:0] m_fifo[$];
  int           m_ids[$];
  bit           m_active, m_none, m_ovf;
  int           m_cnt;

  task automatic m_load(input logic [N-1:0] v);
    m_ids.delete();
    m_cnt = 0;
    for (int i = 0; i < N; i++) if (v[i]) begin m_ids.push_back(i); m_cnt++; end
    m_none   = (m_cnt == 0);
    m_active = 1'b1;
  endtask

  // Drive inputs, clock once, update the model, then compare every output.
  task automatic step(input bit r, input bit vin, input logic [N-1:0] v, input bit rdy);
    bit retire, lastb, pop;
    int pre;
    logic [21:0] e, a;
    rst = r; valid_in = vin; in_vec = v; out_ready = rdy;
    @(posedge clk);
    if (r) begin
      m_fifo.delete(); m_ids.delete();
      m_active = 0; m_none = 0; m_ovf = 0; m_cnt = 0;
    end else begin
      pre    = m_fifo.size();
      retire = m_active && rdy;
      lastb  = m_active && (m_none || m_ids.size() == 1);
      pop    = (pre > 0) && (!m_active || (retire && lastb));
      if (retire) begin
        if (lastb) m_active = 0;
        else void'(m_ids.pop_front());
      end
      if (pop) m_load(m_fifo.pop_front());
      if (vin) begin
        if (pre < DEPTH || pop) m_fifo.push_back(v);
        else m_ovf = 1;
      end
    end
    #1;
    e = {m_active, (m_active && !m_none) ? 7'(m_ids[0]) : 7'd0,
         m_active && (m_none || m_ids.size() == 1), m_active && m_none,
         m_active ? 8'(m_cnt) : 8'd0, 3'(m_fifo.size()), m_ovf};
    a = {id_valid, id_out, id_last, id_none, id_valid ? count_out : 8'd0,
         fifo_level, overflow};
    chk("model", 32'(a), 32'(e));
  endtask

  typedef struct {
    bit           rst;
    bit           vin;
    logic [N-1:0] vec;
    bit           rdy;
    bit           e_valid;
    int           e_id;
    bit           e_last;
    bit           e_none;
    int           e_cnt;
    int           e_level;
  } vec_t;

  vec_t tbl[8];
  int   exp_ids[10];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Vector 0x8005 followed by an all-zero vector, out_ready held high.
    tbl[0] = '{0, 1, 128'h8005, 1, 0, 0, 0, 0, 0, 1};
    tbl[1] = '{0, 0, 128'h0,    1, 1, 0, 0, 0, 3, 0};
    tbl[2] = '{0, 0, 128'h0,    1, 1, 2, 0, 0, 3, 0};
    tbl[3] = '{0, 0, 128'h0,    1, 1, 15, 1, 0, 3, 0};
    tbl[4] = '{0, 0, 128'h0,    1, 0, 0, 0, 0, 0, 0};
    tbl[5] = '{0, 1, 128'h0,    1, 0, 0, 0, 0, 0, 1};
    tbl[6] = '{0, 0, 128'h0,    1, 1, 0, 1, 1, 0, 0};
    tbl[7] = '{0, 0, 128'h0,    1, 0, 0, 0, 0, 0, 0};

    // Reset state.
    step(1, 0, '0, 0);
    step(1, 0, '0, 0);
    chk("reset_outputs",
        32'({id_valid, id_out, id_last, id_none, count_out, fifo_level, overflow}), 32'd0);
    step(0, 0, '0, 0);

    // Table-driven vectors.
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].vin, tbl[i].vec, tbl[i].rdy);
      chk($sformatf("table[%0d]", i),
          32'({id_valid, id_out, id_last, id_none, id_valid ? count_out : 8'd0, fifo_level}),
          32'({tbl[i].e_valid, 7'(tbl[i].e_id), tbl[i].e_last, tbl[i].e_none,
               8'(tbl[i].e_cnt), 3'(tbl[i].e_level)}));
    end

    // All-ones vector: 128 consecutive beats.
    step(0, 1, {N{1'b1}}, 1);
    step(0, 0, '0, 1);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("ones_beat%0d", k), 32'({id_valid, id_out, id_last, count_out}),
          32'({1'b1, 7'(k), (k == N - 1), 8'd128}));
      step(0, 0, '0, 1);
    end
    chk("ones_idle", 32'(id_valid), 32'd0);

    // Stall: vector 0x6, out_ready low for five cycles.
    step(0, 1, 128'h6, 0);
    step(0, 0, '0, 0);
    for (int s = 0; s < 5; s++) begin
      chk($sformatf("stall_hold%0d", s), 32'({id_valid, id_out, id_last, count_out}),
          32'({1'b1, 7'd1, 1'b0, 8'd2}));
      if (s < 4) step(0, 0, '0, 0);
    end
    step(0, 0, '0, 1);
    chk("stall_release", 32'({id_valid, id_out, id_last}), 32'({1'b1, 7'd2, 1'b1}));
    step(0, 0, '0, 1);
    chk("stall_idle", 32'(id_valid), 32'd0);

    // Overflow: six vectors while out_ready is low; v5 is dropped.
    for (int k = 0; k < 6; k++) step(0, 1, 128'h3 << (3 * k), 0);
    chk("ovf_level", 32'(fifo_level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int k = 0; k < 5; k++) begin
      exp_ids[2 * k] = 3 * k;
      exp_ids[2 * k + 1] = 3 * k + 1;
    end
    for (int j = 0; j < 10; j++) begin
      chk($sformatf("ovf_drain%0d", j), 32'({id_valid, id_out}),
          32'({1'b1, 7'(exp_ids[j])}));
      step(0, 0, '0, 1);
    end
    chk("ovf_after", 32'({id_valid, fifo_level, overflow}), 32'({1'b0, 3'd0, 1'b1}));

    // Reset mid-vector: two of five beats retired, two vectors queued.
    step(0, 1, 128'h1F, 1);
    step(0, 1, 128'h3 << 20, 1);
    step(0, 1, 128'h5 << 40, 1);
    step(0, 0, '0, 1);
    chk("pre_rst", 32'({id_valid, id_out, fifo_level}), 32'({1'b1, 7'd2, 3'd2}));
    step(1, 0, '0, 1);
    chk("post_rst", 32'({id_valid, fifo_level, overflow}), 32'd0);
    step(0, 1, 128'h81, 1);
    step(0, 0, '0, 1);
    chk("rst_new0", 32'({id_valid, id_out, id_last, count_out}),
        32'({1'b1, 7'd0, 1'b0, 8'd2}));
    step(0, 0, '0, 1);
    chk("rst_new1", 32'({id_valid, id_out, id_last}), 32'({1'b1, 7'd7, 1'b1}));
    step(0, 0, '0, 1);
    chk("rst_new_idle", 32'(id_valid), 32'd0);

    // Randomized traffic checked against the model on every cycle.
    for (int c = 0; c < 3000; c++) begin
      int           mode;
      logic [N-1:0] v;
      bit           vin, rdy, r;
      mode = $urandom_range(0, 9);
      case (mode)
        0: v = '0;
        1: v = {N{1'b1}};
        2, 3, 4, 5: v = {$urandom(), $urandom(), $urandom(), $urandom()} &
                        {$urandom(), $urandom(), $urandom(), $urandom()} &
                        {$urandom(), $urandom(), $urandom(), $urandom()};
        6, 7: begin v = '0; v[$urandom_range(0, N - 1)] = 1'b1; end
        default: v = {$urandom(), $urandom(), $urandom(), $urandom()};
      endcase
      vin = ($urandom_range(0, 99) < 35);
      rdy = ($urandom_range(0, 99) < 75);
      r   = ($urandom_range(0, 399) == 0);
      step(r, vin, v, rdy);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
